// File: rtl/addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
// Contents: FSM state encoding and operation mode constants.
package addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

// File: rtl/addsub_digit.sv
// Combinational DIGIT-bit ripple-carry slice built from full-adder cells.
// Ports:
//   a_d, b_d  in   DIGIT  operand digits (b_d already inverted for subtraction)
//   cin       in   1      carry into bit 0 of the slice
//   s_d       out  DIGIT  sum digit
//   cout      out  1      carry out of the top bit of the slice
//   c_msb_in  out  1      carry into the top bit of the slice (for signed overflow)
module addsub_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             cin,
    output logic [DIGIT-1:0] s_d,
    output logic             cout,
    output logic             c_msb_in
);

    logic [DIGIT:0] c;

    always_comb begin
        c    = '0;
        s_d  = '0;
        c[0] = cin;
        for (int i = 0; i < DIGIT; i++) begin
            s_d[i]   = a_d[i] ^ b_d[i] ^ c[i];
            c[i+1]   = (a_d[i] & b_d[i]) | (c[i] & (a_d[i] ^ b_d[i]));
        end
    end

    assign cout     = c[DIGIT];
    assign c_msb_in = c[DIGIT-1];

endmodule

// File: rtl/serial_addsub_unit.sv
// Digit-serial two's-complement adder/subtractor, LSB digit first, one reused
// DIGIT-bit ripple slice. WIDTH/DIGIT cycles per operation.
// Optional feature macro: ADDSUB_SAT_EN (clamp result to signed max/min on overflow).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready high only in IDLE)
//   op_a, op_b, sub       operands and mode (1: a-b, 0: a+b), sampled on accept
//   out_valid / out_ready result handshake (out_valid high only in DONE)
//   result                a+b or a-b mod 2^WIDTH (or saturated)
//   cb_out                add: carry out; sub: borrow (a<b unsigned)
//   overflow              signed overflow
module serial_addsub_unit
    import addsub_pkg::*;
#(
    parameter int WIDTH = 6,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cb_out,
    output logic             overflow
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_nxt, res_final;
    logic [CNT_W-1:0] cnt;
    logic             carry, mode;
    logic [WIDTH-1:0] result_q;
    logic             cb_q, ovf_q;

    logic [DIGIT-1:0] s_d;
    logic             cout, c_msb_in;
    logic             accept, last_digit, ovf_nxt, cb_nxt;

    addsub_digit #(.DIGIT(DIGIT)) u_digit (
        .a_d      (a_sr[DIGIT-1:0]),
        .b_d      (b_sr[DIGIT-1:0]),
        .cin      (carry),
        .s_d      (s_d),
        .cout     (cout),
        .c_msb_in (c_msb_in)
    );

    assign accept     = in_valid && in_ready;
    assign last_digit = (cnt == CNT_W'(N - 1));
    assign ovf_nxt    = c_msb_in ^ cout;
    assign cb_nxt     = (mode == MODE_SUB) ? ~cout : cout;

    // New digit enters at the top; after N shifts the LSB digit sits at bit 0.
    always_comb begin
        res_nxt = res_sr >> DIGIT;
        res_nxt[WIDTH-1 -: DIGIT] = s_d;
    end

`ifdef ADDSUB_SAT_EN
    // On overflow the wrapped sign bit is the inverse of the true sign.
    always_comb begin
        res_final = res_nxt;
        if (ovf_nxt) begin
            if (s_d[DIGIT-1])
                res_final = {1'b0, {(WIDTH-1){1'b1}}};
            else
                res_final = {1'b1, {(WIDTH-1){1'b0}}};
        end
    end
`else
    assign res_final = res_nxt;
`endif

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)     state_nxt = BUSY;
            BUSY:    if (last_digit) state_nxt = DONE;
            DONE:    if (out_ready)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // Datapath: operand/result shift registers, digit counter, published result
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            carry    <= 1'b0;
            mode     <= MODE_ADD;
            result_q <= '0;
            cb_q     <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_sr   <= op_a;
                        b_sr   <= sub ? ~op_b : op_b;
                        res_sr <= '0;
                        cnt    <= '0;
                        carry  <= sub;
                        mode   <= sub ? MODE_SUB : MODE_ADD;
                    end
                end
                BUSY: begin
                    a_sr   <= a_sr >> DIGIT;
                    b_sr   <= b_sr >> DIGIT;
                    res_sr <= res_nxt;
                    carry  <= cout;
                    cnt    <= cnt + CNT_W'(1);
                    // Only the finished value is published, never a partial one.
                    if (last_digit) begin
                        result_q <= res_final;
                        cb_q     <= cb_nxt;
                        ovf_q    <= ovf_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result   = result_q;
    assign cb_out   = cb_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub_unit.sv
module tb_serial_addsub_unit;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, sub, out_valid, out_ready, cb_out, overflow;
    logic [5:0] op_a, op_b, result;

    logic       in_valid3, in_ready3, sub3, out_valid3, out_ready3, cb_out3, overflow3;
    logic [5:0] op_a3, op_b3, result3;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_addsub_unit #(.WIDTH(6), .DIGIT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cb_out(cb_out), .overflow(overflow)
    );

    serial_addsub_unit #(.WIDTH(6), .DIGIT(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid3), .in_ready(in_ready3),
        .op_a(op_a3), .op_b(op_b3), .sub(sub3),
        .out_valid(out_valid3), .out_ready(out_ready3),
        .result(result3), .cb_out(cb_out3), .overflow(overflow3)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full operation on the DIGIT=1 unit; operands are scrambled after accept.
    task automatic do_op(input string tag, input logic [5:0] a, input logic [5:0] b,
                         input logic s, input logic [5:0] er, input logic ecb, input logic eov);
        int cyc;
        cyc = 0;
        while (!in_ready && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_val({tag, "_in_ready"}, in_ready, 1);
        op_a = a; op_b = b; sub = s; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = ~a; op_b = ~b; sub = ~s;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_val({tag, "_latency"}, cyc, 6);
        check_val({tag, "_result"}, result, er);
        check_val({tag, "_cb"}, cb_out, ecb);
        check_val({tag, "_ovf"}, overflow, eov);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val({tag, "_idle"}, {out_valid, in_ready}, 2'b01);
    endtask

    logic [5:0] sat_res_a, sat_res_b;
    logic [5:0] held;
    int         cyc;

    initial begin
`ifdef ADDSUB_SAT_EN
        sat_res_a = 6'b011111;
        sat_res_b = 6'b100000;
`else
        sat_res_a = 6'b100000;
        sat_res_b = 6'b011111;
`endif
        rst_n = 1'b0;
        in_valid = 0; op_a = 0; op_b = 0; sub = 0; out_ready = 0;
        in_valid3 = 0; op_a3 = 0; op_b3 = 0; sub3 = 0; out_ready3 = 0;
        #12;
        check_val("reset_state", {in_ready, out_valid, result, cb_out, overflow}, {1'b1, 1'b0, 6'd0, 1'b0, 1'b0});
        check_val("reset_state3", {in_ready3, out_valid3, result3}, {1'b1, 1'b0, 6'd0});
        rst_n = 1'b1;
        @(posedge clk); #1;

        do_op("sub_basic", 6'b110110, 6'b101001, 1'b1, 6'b001101, 1'b0, 1'b0);
        do_op("add_wrap",  6'b111111, 6'b000001, 1'b0, 6'b000000, 1'b1, 1'b0);
        do_op("sub_borrow",6'b000000, 6'b000001, 1'b1, 6'b111111, 1'b1, 1'b0);
        do_op("add_ovf",   6'b011111, 6'b000001, 1'b0, sat_res_a, 1'b0, 1'b1);
        do_op("sub_ovf",   6'b100000, 6'b000001, 1'b1, sat_res_b, 1'b0, 1'b1);
        do_op("add_alt",   6'b101010, 6'b010101, 1'b0, 6'b111111, 1'b0, 1'b0);
        do_op("sub_equal", 6'b100101, 6'b100101, 1'b1, 6'b000000, 1'b0, 1'b0);

        // Backpressure: hold DONE for 3 cycles while a new request is offered
        op_a = 6'b000101; op_b = 6'b000010; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; op_a = 6'b111000; op_b = 6'b000111; sub = 1'b1;
        cyc = 0;
        while (!out_valid && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_val("bp_latency", cyc, 6);
        held = result;
        check_val("bp_result", held, 6'b000111);
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_val("bp_hold", {out_valid, in_ready, result, cb_out, overflow}, {1'b1, 1'b0, 6'b000111, 1'b0, 1'b0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_val("bp_release", {out_valid, in_ready}, 2'b01);
        repeat (8) @(posedge clk);
        #1;
        check_val("bp_no_phantom", {out_valid, in_ready}, 2'b01);

        // Reset during the 3rd BUSY cycle
        op_a = 6'b110110; op_b = 6'b101001; sub = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("rst_mid", {out_valid, in_ready, result, cb_out, overflow}, {1'b0, 1'b1, 6'd0, 1'b0, 1'b0});
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_op("post_rst", 6'b000011, 6'b000100, 1'b0, 6'b000111, 1'b0, 1'b0);

        // DIGIT=3 unit: same first vector, two cycles per operation
        op_a3 = 6'b110110; op_b3 = 6'b101001; sub3 = 1'b1; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0; op_a3 = 6'b000000; op_b3 = 6'b111111; sub3 = 1'b0;
        cyc = 0;
        while (!out_valid3 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_val("d3_latency", cyc, 2);
        check_val("d3_result", {result3, cb_out3, overflow3}, {6'b001101, 1'b0, 1'b0});
        out_ready3 = 1'b1;
        @(posedge clk); #1;
        out_ready3 = 1'b0;
        check_val("d3_idle", {out_valid3, in_ready3}, 2'b01);

        op_a3 = 6'b011111; op_b3 = 6'b000001; sub3 = 1'b0; in_valid3 = 1'b1;
        @(posedge clk); #1;
        in_valid3 = 1'b0;
        cyc = 0;
        while (!out_valid3 && cyc < 20) begin @(posedge clk); #1; cyc++; end
        check_val("d3_ovf_latency", cyc, 2);
        check_val("d3_ovf", {result3, cb_out3, overflow3}, {sat_res_a, 1'b0, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
